// File: rtl/sha256_kt_seq_if.sv
// sha256_kt_seq_if
// Bundles the signals between the block scheduler, the Kt address sequencer
// and the consumers of the round tags.
//   start, n_blocks, stall : scheduler -> sequencer (request, block count, freeze)
//   ready                  : sequencer idle, start will be accepted
//   Kt_en, Kt_t            : Kt memory read enable / address
//   rnd_valid, rnd         : round tag aligned with the Kt memory output
//   rnd_first, rnd_last    : tag is round 0 / round 63
//   blk_last               : tagged round belongs to the final block
//   done                   : one-cycle pulse when the whole request has drained
// master = scheduler side, slave = sequencer side.
interface sha256_kt_seq_if;
    logic       start;
    logic [3:0] n_blocks;
    logic       stall;
    logic       ready;
    logic       Kt_en;
    logic [6:0] Kt_t;
    logic       rnd_valid;
    logic [5:0] rnd;
    logic       rnd_first;
    logic       rnd_last;
    logic       blk_last;
    logic       done;

    modport master (
        output start, n_blocks, stall,
        input  ready, Kt_en, Kt_t, rnd_valid, rnd, rnd_first, rnd_last,
               blk_last, done
    );

    modport slave (
        input  start, n_blocks, stall,
        output ready, Kt_en, Kt_t, rnd_valid, rnd, rnd_first, rnd_last,
               blk_last, done
    );
endinterface

// File: rtl/sha256_kt_seq.sv
// sha256_kt_seq
// Walks the Kt constant table once per requested block (7 leading zero slots,
// K0..K63, one trailing zero slot) and emits round tags delayed to line up
// with the registered Kt memory output.
// Ports:
//   CLK  : clock
//   rst  : asynchronous active-high reset
//   bus  : sha256_kt_seq_if.slave (start/n_blocks/stall in; ready, Kt_en,
//          Kt_t, rnd_valid, rnd, rnd_first, rnd_last, blk_last, done out)
module sha256_kt_seq #(
    parameter int N_CYCLES = 72,
    parameter int K_FIRST  = 7,
    parameter int N_ROUNDS = 64,
    parameter int RD_LAT   = 2
) (
    input  logic                 CLK,
    input  logic                 rst,
    sha256_kt_seq_if.slave       bus
);
    localparam int DW = $clog2(RD_LAT + 1);
    localparam logic [6:0]    LAST_T    = 7'(N_CYCLES - 1);
    localparam logic [6:0]    FIRST_T   = 7'(K_FIRST);
    localparam logic [6:0]    END_T     = 7'(K_FIRST + N_ROUNDS);
    localparam logic [DW-1:0] DRN_LAST  = DW'(RD_LAT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic       vld;
        logic       last;
        logic [5:0] rnd;
    } tag_t;

    state_t        state_reg, state_next;
    logic [6:0]    t_reg, t_next;
    logic [3:0]    blk_rem_reg, blk_rem_next;
    logic [DW-1:0] drn_reg, drn_next;
    tag_t [RD_LAT-1:0] pipe_reg;

    logic          issue;
    logic [6:0]    t_off;
    tag_t          tag_in;

    // A slot is only issued in RUN and only when not frozen; everything else
    // (idle, drain, stalled cycles) feeds a bubble into the tag pipeline.
    assign issue = (state_reg == RUN) && !bus.stall;
    assign t_off = t_reg - FIRST_T;

    always_comb begin
        tag_in      = '0;
        tag_in.vld  = issue && (t_reg >= FIRST_T) && (t_reg < END_T);
        tag_in.last = tag_in.vld && (blk_rem_reg == 4'd0);
        tag_in.rnd  = tag_in.vld ? t_off[5:0] : 6'd0;
    end

    // State register
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            t_reg       <= '0;
            blk_rem_reg <= '0;
            drn_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            t_reg       <= t_next;
            blk_rem_reg <= blk_rem_next;
            drn_reg     <= drn_next;
        end
    end

    // Tag pipeline advances every cycle regardless of stall, so a frozen
    // issue cycle shows up at the tail as exactly one empty cycle.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            pipe_reg <= '0;
        end else begin
            pipe_reg[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        t_next       = t_reg;
        blk_rem_next = blk_rem_reg;
        drn_next     = drn_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    // A block count of zero still runs one block.
                    blk_rem_next = (bus.n_blocks == 4'd0) ? 4'd0 : bus.n_blocks - 4'd1;
                    t_next       = '0;
                    state_next   = RUN;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    if (t_reg == LAST_T) begin
                        t_next = '0;
                        if (blk_rem_reg != 4'd0) begin
                            // Next block starts on the very next cycle.
                            blk_rem_next = blk_rem_reg - 4'd1;
                        end else begin
                            drn_next   = '0;
                            state_next = DRAIN;
                        end
                    end else begin
                        t_next = t_reg + 7'd1;
                    end
                end
            end
            DRAIN: begin
                if (drn_reg == DRN_LAST) begin
                    drn_next   = '0;
                    state_next = IDLE;
                end else begin
                    drn_next = drn_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.ready     = (state_reg == IDLE);
        bus.Kt_en     = issue;
        bus.Kt_t      = (state_reg == RUN) ? t_reg : 7'd0;
        bus.done      = (state_reg == DRAIN) && (drn_reg == DRN_LAST);
        bus.rnd_valid = pipe_reg[RD_LAT-1].vld;
        bus.rnd       = pipe_reg[RD_LAT-1].rnd;
        bus.blk_last  = pipe_reg[RD_LAT-1].last;
        bus.rnd_first = pipe_reg[RD_LAT-1].vld && (pipe_reg[RD_LAT-1].rnd == 6'd0);
        bus.rnd_last  = pipe_reg[RD_LAT-1].vld && (pipe_reg[RD_LAT-1].rnd == 6'd63);
    end
endmodule

// File: tb/tb_sha256_kt_seq.sv
module tb_sha256_kt_seq;
    logic CLK = 1'b0;
    logic rst = 1'b0;

    always #5 CLK = ~CLK;

    sha256_kt_seq_if bus();

    sha256_kt_seq dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       en;
        logic [6:0] t;
    } iss_t;

    typedef struct {
        int         due;
        logic [5:0] r;
        logic       bl;
    } tag_t;

    iss_t iq[$];
    tag_t tq[$];
    int   dq[$];

    int   rl_cyc  = 0;
    int   n_valid = 0;
    iss_t ie;
    tag_t te;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, pops expectations
    // pushed by the stimulus.
    initial begin
        forever begin
            @(negedge CLK);
            if (!rst) begin
                if (iq.size() > 0) begin
                    ie = iq.pop_front();
                    chk("kt_en", 32'(bus.Kt_en), 32'(ie.en));
                    if (ie.en) chk("kt_t", 32'(bus.Kt_t), 32'(ie.t));
                end else begin
                    chk("kt_en_idle", 32'(bus.Kt_en), 32'd0);
                end

                if (bus.rnd_valid) begin
                    n_valid++;
                    if (tq.size() == 0) begin
                        chk("rnd_extra", 32'(bus.rnd_valid), 32'd0);
                    end else begin
                        te = tq.pop_front();
                        chk("rnd", 32'(bus.rnd), 32'(te.r));
                        chk("blk_last", 32'(bus.blk_last), 32'(te.bl));
                        chk("rnd_cycle", cyc, te.due);
                        chk("rnd_first", 32'(bus.rnd_first), 32'(te.r == 6'd0));
                        chk("rnd_last", 32'(bus.rnd_last), 32'(te.r == 6'd63));
                        if (bus.rnd_last) rl_cyc = cyc;
                    end
                end else begin
                    if (tq.size() > 0 && tq[0].due <= cyc) begin
                        chk("rnd_missing", 32'(bus.rnd_valid), 32'd1);
                        tq.delete(0);
                    end
                    chk("rnd_first_idle", 32'(bus.rnd_first), 32'd0);
                    chk("rnd_last_idle", 32'(bus.rnd_last), 32'd0);
                end

                if (bus.done) begin
                    if (dq.size() == 0) begin
                        chk("done_extra", 32'(bus.done), 32'd0);
                    end else begin
                        chk("done_cycle", cyc, dq.pop_front());
                    end
                end else if (dq.size() > 0 && dq[0] <= cyc) begin
                    chk("done_missing", 32'(bus.done), 32'd1);
                    dq.delete(0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"},     32'(bus.ready),     32'd1);
        chk({tag, "_kt_en"},     32'(bus.Kt_en),     32'd0);
        chk({tag, "_kt_t"},      32'(bus.Kt_t),      32'd0);
        chk({tag, "_rnd_valid"}, 32'(bus.rnd_valid), 32'd0);
        chk({tag, "_rnd"},       32'(bus.rnd),       32'd0);
        chk({tag, "_rnd_first"}, 32'(bus.rnd_first), 32'd0);
        chk({tag, "_rnd_last"},  32'(bus.rnd_last),  32'd0);
        chk({tag, "_blk_last"},  32'(bus.blk_last),  32'd0);
        chk({tag, "_done"},      32'(bus.done),      32'd0);
    endtask

    // One request: start, walk the table with optional stalls/start spam,
    // optionally reset when slot rst_at_t is about to issue.
    task automatic run(input int nb, input bit stall_on, input bit spam,
                       input int rst_at_t, output int first_cyc);
        int  w;
        int  nbe;
        int  k;
        int  t;
        int  blk;
        int  last;
        bit  fin;
        bit  st;
        w = 0;
        while (bus.ready !== 1'b1 && w < 200) begin
            @(posedge CLK); #1;
            w++;
        end
        chk("ready_before_start", 32'(bus.ready), 32'd1);
        bus.n_blocks = nb[3:0];
        bus.start    = 1'b1;
        @(posedge CLK); #1;
        bus.start = spam;
        first_cyc = cyc;
        nbe = (nb == 0) ? 1 : nb;
        k = 0; t = 0; blk = 0; fin = 1'b0;
        while (!fin) begin
            st = stall_on && ((k >= 20 && k <= 24) || k == 70 || k == 71);
            if (rst_at_t >= 0 && t == rst_at_t) begin
                chk("rnd_before_rst", 32'(bus.rnd), 32'(rst_at_t - 9));
                rst = 1'b1;
                #1;
                check_idle_outputs("rst_mid");
                iq.delete(); tq.delete(); dq.delete();
                bus.start = 1'b0;
                bus.stall = 1'b0;
                @(posedge CLK); #1;
                rst = 1'b0;
                return;
            end
            bus.stall = st;
            if (st) begin
                iq.push_back(iss_t'{1'b0, 7'(t)});
            end else begin
                iq.push_back(iss_t'{1'b1, 7'(t)});
                if (t >= 7 && t <= 70)
                    tq.push_back(tag_t'{cyc + 2, 6'(t - 7), (blk == nbe - 1)});
                if (t == 71) begin
                    t = 0;
                    if (blk == nbe - 1) fin = 1'b1;
                    else blk++;
                end else begin
                    t++;
                end
            end
            @(posedge CLK); #1;
            k++;
        end
        last = cyc - 1;
        dq.push_back(last + 3);
        bus.stall = stall_on;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("ready_in_done_cycle", 32'(bus.ready), 32'd0);
        @(posedge CLK); #1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        chk("ready_after_done", 32'(bus.ready), 32'd1);
    endtask

    int f;
    int rl_nostall;
    int rl_stall;

    initial begin
        bus.start    = 1'b0;
        bus.stall    = 1'b0;
        bus.n_blocks = 4'd0;
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("reset");
        @(posedge CLK); @(posedge CLK); #1;
        rst = 1'b0;

        // single block, no stall
        n_valid = 0;
        run(1, 1'b0, 1'b0, -1, f);
        rl_nostall = rl_cyc - f;
        chk("nb1_valid_count", n_valid, 64);
        chk("nb1_rnd_last_offset", rl_nostall, 72);

        // three back-to-back blocks
        n_valid = 0;
        run(3, 1'b0, 1'b0, -1, f);
        chk("nb3_valid_count", n_valid, 192);
        chk("nb3_rnd_last_offset", rl_cyc - f, 216);

        // zero block count behaves as one
        n_valid = 0;
        run(0, 1'b0, 1'b0, -1, f);
        chk("nb0_valid_count", n_valid, 64);
        chk("nb0_rnd_last_offset", rl_cyc - f, 72);

        // stalls: 5 cycles, then two single cycles
        n_valid = 0;
        run(1, 1'b1, 1'b0, -1, f);
        rl_stall = rl_cyc - f;
        chk("stall_valid_count", n_valid, 64);
        chk("stall_rnd_last_delay", rl_stall - rl_nostall, 7);

        // start held high through RUN and DRAIN
        n_valid = 0;
        run(1, 1'b0, 1'b1, -1, f);
        chk("spam_valid_count", n_valid, 64);
        repeat (5) begin
            @(posedge CLK); #1;
        end
        chk("spam_still_ready", 32'(bus.ready), 32'd1);

        // reset while rnd=30 is on the output, then restart
        run(1, 1'b0, 1'b0, 39, f);
        chk("post_rst_ready", 32'(bus.ready), 32'd1);
        n_valid = 0;
        run(1, 1'b0, 1'b0, -1, f);
        chk("post_rst_valid_count", n_valid, 64);
        chk("post_rst_rnd_last_offset", rl_cyc - f, 72);

        repeat (4) begin
            @(posedge CLK); #1;
        end
        chk("queues_empty", iq.size() + tq.size() + dq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
